// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: pcsel encodings, opcode slice bounds, reset PC and queue entry layouts
package fetch_unit_pkg;
  typedef enum logic [1:0] {
    PCSEL_PC4 = 2'd0,
    PCSEL_BR  = 2'd1,
    PCSEL_JMP = 2'd2,
    PCSEL_RSV = 2'd3
  } pcsel_e;
  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef struct packed {
    logic        epoch;
    logic [31:0] pc;
  } tag_t;
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } inst_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch-stage bus bundle
//   imem_req_*/imem_addr : request channel to instruction memory
//   imem_rsp_*           : in-order response channel from memory
//   redir_valid/pcsel/br_target/jmp_target : redirect from decode
//   inst_*               : instruction channel to decode
//   master = fetch unit side, slave = memory/decode side
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redir_valid;
  logic [1:0]  pcsel;
  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redir_valid, pcsel,
           br_target, jmp_target, inst_ready
  );
  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redir_valid, pcsel,
           br_target, jmp_target, inst_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry FIFO with synchronous flush
//   push_i/din_i : write; ignored when full unless a pop happens in the same cycle
//   pop_i        : read; ignored when empty
//   flush_i      : empties the FIFO, dominating push and pop
//   dout_o       : head entry, cnt_o : occupancy 0..2
module fetch_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   cnt_o
);
  logic [W-1:0] mem_q [2];
  logic         rd_q, wr_q;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;
  assign do_pop  = pop_i && cnt_q != 2'd0;
  // When full, wr_q == rd_q: a simultaneous pop frees the very slot being written.
  assign do_push = push_i && (cnt_q != 2'd2 || do_pop);
  assign cnt_d   = flush_i ? 2'd0 : cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      if (flush_i) begin
        rd_q <= 1'b0;
        wr_q <= 1'b0;
      end else begin
        if (do_push) begin
          mem_q[wr_q] <= din_i;
          wr_q        <= ~wr_q;
        end
        if (do_pop) rd_q <= ~rd_q;
      end
    end
  assign dout_o = mem_q[rd_q];
  assign cnt_o  = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, credit-limited imem requests, epoch-tagged responses, 2-entry instruction queue
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : fetch_unit_if.master (imem request/response, redirect, instruction out)
//   fetch_fault : sticky misaligned-redirect trap, present only with FETCH_MISALIGN_TRAP_EN
// Without FETCH_MISALIGN_TRAP_EN, target bits [1:0] are cleared when loaded into the PC.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic         fetch_fault
`endif
);
  logic [31:0] pc_q, pc_d, target;
  logic        epoch_q, epoch_d, fault_q;
  logic        redirect, req_fire, rsp_keep, inst_pop;
  logic [1:0]  tag_cnt, iq_cnt;
  tag_t        tag_head;
  inst_t       iq_head;
  assign redirect = bus.redir_valid && (bus.pcsel == PCSEL_BR || bus.pcsel == PCSEL_JMP);
  assign target   = bus.pcsel == PCSEL_BR ? bus.br_target : bus.jmp_target;
  // Tag queue occupancy is the outstanding count; capping it plus the instruction
  // queue at 2 guarantees every response finds room, so responses are never stalled.
  assign bus.imem_req_valid = !redirect && !fault_q && ({1'b0, tag_cnt} + {1'b0, iq_cnt} < 3'd2);
  assign bus.imem_addr      = pc_q;
  assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_keep  = bus.imem_rsp_valid && !redirect && tag_head.epoch == epoch_q;
  assign bus.inst_valid = iq_cnt != 2'd0 && !fault_q;
  assign inst_pop  = bus.inst_valid && bus.inst_ready;
  assign bus.inst    = iq_head.data;
  assign bus.inst_pc = iq_head.pc;
  assign pc_d    = redirect ? (target & ~32'd3) : req_fire ? pc_q + 32'd4 : pc_q;
  assign epoch_d = epoch_q ^ redirect;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      epoch_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
    end
`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_d;
  assign fault_d = fault_q || (redirect && target[1:0] != 2'b00);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fault_q <= 1'b0;
    else fault_q <= fault_d;
  assign fetch_fault = fault_q;
`else
  assign fault_q = 1'b0;
`endif
  // Tags are never flushed: stale requests stay counted until their responses drain.
  fetch_fifo #(.W(33)) u_tag_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (req_fire),
    .pop_i   (bus.imem_rsp_valid),
    .flush_i (1'b0),
    .din_i   ({epoch_q, pc_q}),
    .dout_o  (tag_head),
    .cnt_o   (tag_cnt)
  );
  fetch_fifo #(.W(64)) u_inst_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rsp_keep),
    .pop_i   (inst_pop),
    .flush_i (redirect),
    .din_i   ({bus.imem_rsp_data, tag_head.pc}),
    .dout_o  (iq_head),
    .cnt_o   (iq_cnt)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench with memory model, redirect vector table and corner sequences
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  typedef struct {
    logic        rv;
    logic [1:0]  sel;
    logic [31:0] br;
    logic [31:0] jmp;
    logic        exp_req;
    logic        exp_redir;
    logic [31:0] exp_addr;
  } vec_t;
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0, last_due = -1;
  int p_rdy = 100, p_irdy = 100, dmin = 1, dmax = 1;
  int fires = 0, delivered = 0, first_fire = -1, first_iv = -1;
  logic [31:0] model_pc = RESET_PC_DEFAULT;
  logic [31:0] last_pc = '1;
  logic        settle_req;
  logic [31:0] exp_q[$];
  logic [31:0] fire_log[$];
  pend_t       pend[$];
  vec_t        vecs[$];
  fetch_unit_if bus();
`ifdef FETCH_MISALIGN_TRAP_EN
  logic fetch_fault;
  fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus), .fetch_fault(fetch_fault));
`else
  fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic clear_model();
    pend.delete();
    exp_q.delete();
    model_pc = RESET_PC_DEFAULT;
    last_due = -1;
  endtask
  // One cycle: drive memory/decode inputs, settle, score, then advance past the edge.
  task automatic step();
    int          due;
    logic        redir;
    logic [31:0] e;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = word(pend[0].addr);
    end
    bus.imem_req_ready = int'($urandom_range(99)) < p_rdy;
    bus.inst_ready     = int'($urandom_range(99)) < p_irdy;
    #1;
    redir = bus.redir_valid && (bus.pcsel == 2'd1 || bus.pcsel == 2'd2);
    settle_req = bus.imem_req_valid;
    if (bus.imem_rsp_valid) void'(pend.pop_front());
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      chk("imem_addr", bus.imem_addr, model_pc);
      model_pc += 32'd4;
      due = cyc + int'($urandom_range(dmax, dmin));
      if (due <= last_due) due = last_due + 1;
      pend.push_back('{bus.imem_addr, due});
      last_due = due;
      exp_q.push_back(bus.imem_addr);
      fire_log.push_back(bus.imem_addr);
      if (first_fire < 0) first_fire = cyc;
      fires++;
    end
    if (bus.inst_valid && first_iv < 0) first_iv = cyc;
    if (redir) begin
      exp_q.delete();
      model_pc = (bus.pcsel == 2'd1 ? bus.br_target : bus.jmp_target) & ~32'd3;
    end else if (bus.inst_valid && bus.inst_ready) begin
      delivered++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_inst: got pc %h with nothing expected", bus.inst_pc);
      end else begin
        e = exp_q.pop_front();
        last_pc = bus.inst_pc;
        chk("inst_pc", bus.inst_pc, e);
        chk("inst", bus.inst, word(e));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic drain();
    p_rdy  = 0;
    p_irdy = 100;
    repeat (8) step();
  endtask
  initial begin
    logic [31:0] prev;
    int          f0, d0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redir_valid    = 1'b0;
    bus.pcsel          = 2'd0;
    bus.br_target      = '0;
    bus.jmp_target     = '0;
    bus.inst_ready     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_addr", bus.imem_addr, RESET_PC_DEFAULT);
    chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
`endif
    rst_n = 1'b1;
    // Startup: memory always ready, one-cycle response.
    step();
    chk("first_req_valid", {31'd0, settle_req}, 32'd1);
    repeat (9) step();
    chk("start_addr0", fire_log[0], 32'h0);
    chk("start_addr1", fire_log[1], 32'h4);
    chk("start_addr2", fire_log[2], 32'h8);
    chk("first_latency", first_iv - first_fire, 32'd2);
    // Decode stalled: exactly two requests until a pop frees credit.
    drain();
    p_rdy  = 100;
    p_irdy = 0;
    f0 = fires;
    repeat (5) step();
    chk("stall_fires", fires - f0, 32'd2);
    chk("stall_queued", exp_q.size(), 32'd2);
    chk("stall_inst_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("stall_head_pc", bus.inst_pc, exp_q[0]);
    chk("stall_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    p_irdy = 100;
    step();
    chk("resume_req", {31'd0, bus.imem_req_valid}, 32'd1);
    // Branch while two requests are outstanding.
    drain();
    p_rdy = 100;
    dmin  = 3;
    dmax  = 3;
    step();
    step();
    chk("two_outstanding", pend.size(), 32'd2);
    bus.redir_valid = 1'b1;
    bus.pcsel       = 2'd1;
    bus.br_target   = 32'h100;
    bus.jmp_target  = 32'h7777_0000;
    step();
    bus.redir_valid = 1'b0;
    bus.pcsel       = 2'd0;
    chk("br_addr", bus.imem_addr, 32'h100);
    chk("br_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    dmin = 1;
    dmax = 1;
    d0 = delivered;
    for (int i = 0; i < 20 && delivered == d0; i++) step();
    chk("br_first_pc", last_pc, 32'h100);
    // Redirect vector table, memory held not-ready so the PC only moves on redirects.
    drain();
    vecs.push_back('{1'b1, 2'd3, 32'h200, 32'h300, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 2'd1, 32'h200, 32'h300, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 2'd2, 32'h200, 32'h300, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 2'd0, 32'h200, 32'h300, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 2'd1, 32'h200, 32'h300, 1'b0, 1'b1, 32'h200});
    vecs.push_back('{1'b1, 2'd2, 32'h200, 32'h340, 1'b0, 1'b1, 32'h340});
    vecs.push_back('{1'b1, 2'd3, 32'h500, 32'h600, 1'b1, 1'b0, 32'h0});
`ifndef FETCH_MISALIGN_TRAP_EN
    vecs.push_back('{1'b1, 2'd1, 32'h203, 32'h0, 1'b0, 1'b1, 32'h200});
    vecs.push_back('{1'b1, 2'd2, 32'h0, 32'h102, 1'b0, 1'b1, 32'h100});
`endif
    vecs.push_back('{1'b1, 2'd2, 32'h1000, 32'hFFFF_FFF8, 1'b0, 1'b1, 32'hFFFF_FFF8});
    foreach (vecs[i]) begin
      prev = bus.imem_addr;
      bus.redir_valid = vecs[i].rv;
      bus.pcsel       = vecs[i].sel;
      bus.br_target   = vecs[i].br;
      bus.jmp_target  = vecs[i].jmp;
      step();
      bus.redir_valid = 1'b0;
      bus.pcsel       = 2'd0;
      chk($sformatf("vec%0d_req_valid", i), {31'd0, settle_req}, {31'd0, vecs[i].exp_req});
      chk($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].exp_redir ? vecs[i].exp_addr : prev);
      if (vecs[i].exp_redir) chk($sformatf("vec%0d_inst_valid", i), {31'd0, bus.inst_valid}, 32'd0);
    end
    // Fetch across the 2^32 wrap after the table.
    p_rdy = 100;
    d0 = delivered;
    repeat (20) step();
    chk("wrap_delivery", {31'd0, delivered - d0 >= 4}, 32'd1);
    // Random memory readiness, 1-3 cycle latency, decode stalls, sporadic redirects.
    p_rdy  = 60;
    p_irdy = 70;
    dmin   = 1;
    dmax   = 3;
    d0 = delivered;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 3) begin
        bus.redir_valid = $urandom_range(3) != 0;
        bus.pcsel       = 2'($urandom_range(3));
        bus.br_target   = $urandom & ~32'd3;
        bus.jmp_target  = $urandom & ~32'd3;
      end
      step();
      bus.redir_valid = 1'b0;
      bus.pcsel       = 2'd0;
    end
    drain();
    chk("random_drained", exp_q.size(), 32'd0);
    chk("random_progress", {31'd0, delivered - d0 > 100}, 32'd1);
`ifdef FETCH_MISALIGN_TRAP_EN
    bus.redir_valid = 1'b1;
    bus.pcsel       = 2'd2;
    bus.jmp_target  = 32'h102;
    step();
    bus.redir_valid = 1'b0;
    bus.pcsel       = 2'd0;
    chk("fault_set", {31'd0, fetch_fault}, 32'd1);
    chk("fault_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("fault_no_inst", {31'd0, bus.inst_valid}, 32'd0);
    p_rdy = 100;
    f0 = fires;
    repeat (6) step();
    chk("fault_halted", fires - f0, 32'd0);
    chk("fault_sticky", {31'd0, fetch_fault}, 32'd1);
`endif
    // Asynchronous reset in the middle of traffic.
    p_rdy = 100;
    dmin  = 1;
    dmax  = 1;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_addr", bus.imem_addr, RESET_PC_DEFAULT);
    chk("async_rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("async_rst_fault", {31'd0, fetch_fault}, 32'd0);
`endif
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    d0 = delivered;
    repeat (10) step();
    chk("post_rst_first_pc", {31'd0, delivered > d0}, 32'd1);
    drain();
    chk("final_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits in front of the control decoder. It is the consumer of the decoder's `pcsel` redirect outputs and the producer of the instruction words whose opcode field the decoder consumes. The unit holds the program counter, issues requests to instruction memory with a valid/ready handshake, and buffers returned words in a 2-entry queue. It discards stale responses after a branch or jump redirect and presents instructions to decode with a valid/ready handshake.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request this cycle.
- `imem_addr`  out  32  fetch address; equals current PC.
- `imem_rsp_valid`  in  1  response word valid; responses return in request order.
- `imem_rsp_data`  in  32  instruction word.
- `redir_valid`  in  1  qualifies `pcsel` from decode.
- `pcsel`  in  2  0 = pc+4 (no redirect), 1 = branch, 2 = jump, 3 = reserved (ignored).
- `br_target`  in  32  branch target, used when `pcsel` = 1.
- `jmp_target`  in  32  jump target, used when `pcsel` = 2.
- `inst_valid`  out  1  instruction available to decode.
- `inst_ready`  in  1  decode consumes the instruction.
- `inst`  out  32  instruction word; bits [6:0] feed the decoder opcode.
- `inst_pc`  out  32  address of `inst`.
- `fetch_fault`  out  1  misaligned target trap. Only present with `FETCH_MISALIGN_TRAP_EN`; see Configuration.

## Operation
- A request fires when `imem_req_valid && imem_req_ready`. On each fire, PC advances by 4 (mod 2^32) and the request's PC and current epoch are pushed into a 2-deep tag queue.
- Credit rule: `imem_req_valid` = !redirect_now && (outstanding + queue_count) < 2. A response therefore always has space in the queue, and `imem_rsp_valid` is never back-pressured.
- On a response, the tag queue pops. If the tag epoch equals the current epoch, {data, tag PC} is written to the instruction queue. Otherwise the response is dropped.
- The instruction queue is a 2-entry FIFO. Its head drives `inst`, `inst_pc` and `inst_valid`. A pop occurs on `inst_valid && inst_ready`.
- redirect_now = `redir_valid && (pcsel == 1 || pcsel == 2)`. On a redirect:
  - PC is loaded with the selected target.
  - The epoch bit toggles.
  - The instruction queue is flushed.
  - Outstanding requests remain counted until their responses return, and are dropped on return.
- Simultaneous events:
  - If a redirect coincides with a response, the response is dropped.
  - If a redirect coincides with a pop, the flush dominates.
  - If a push and a pop occur in the same cycle on a full queue, both are legal: count stays 2.
- `pcsel` = 0 or 3, or `redir_valid` = 0, leaves the fetch sequence unaffected.

## Timing
- Reset values: PC = `RESET_PC`, epoch = 0, outstanding = 0, queue empty. Outputs: `imem_req_valid` = 1 from the first cycle after `rst_n` deasserts, `imem_addr` = `RESET_PC`, `inst_valid` = 0, `inst` = 0, `inst_pc` = 0, `fetch_fault` = 0.
- `imem_addr` is combinational from the PC register.
- A response in cycle N produces `inst_valid` in cycle N+1, because the queue is registered. Best-case fetch-to-decode latency is 2 cycles when memory returns one cycle after accept.
- A redirect in cycle N suppresses the request in cycle N. The first request at the target issues in cycle N+1, and `inst_valid` is 0 in cycle N+1.
- Reset asserted mid-operation clears all state immediately. Responses arriving after reset for pre-reset requests are illegal; the memory is reset by the same `rst_n`.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect target with bits [1:0] != 0 sets sticky `fetch_fault` = 1 one cycle after the redirect.
  - While the fault is set, `imem_req_valid` = 0 and `inst_valid` = 0.
  - Only reset clears it.
- Undefined: the `fetch_fault` port is absent, and target bits [1:0] are forced to 0 when loaded into PC.

## Structure
- Shared package holds:
  - `pcsel` encodings: `PCSEL_PC4` = 0, `PCSEL_BR` = 1, `PCSEL_JMP` = 2.
  - Opcode field slice constants (`OPC_LSB` = 0, `OPC_MSB` = 6).
  - Default `RESET_PC`.
- Sub-module `fetch_fifo` is a parameterised-width, 2-entry FIFO with flush. It is instantiated twice: once as the tag queue (33 bits: epoch + PC) and once as the instruction queue (64 bits).

## Test plan
- Reset release with memory always ready and 1-cycle response: `imem_addr` sequence is 0x0, 0x4, 0x8. The first `inst_valid` occurs 2 cycles after the first accept, with `inst_pc` = 0x0.
- `inst_ready` = 0 for 5 cycles: at most 2 requests are issued, the queue holds 0x0 and 0x4, and no further request fires until a pop.
- Redirect with `pcsel` = 1, `br_target` = 0x100, while 2 responses are outstanding: both stale words are dropped, and the next delivered `inst_pc` = 0x100.
- Redirect with `pcsel` = 3 and `redir_valid` = 1: the PC sequence is unchanged and the epoch does not toggle.
- `imem_req_ready` toggling randomly, with response delay of 1–3 cycles: `inst_pc` is strictly sequential in steps of +4 and no word is lost or duplicated.
- With `FETCH_MISALIGN_TRAP_EN`, a jump to 0x102: `fetch_fault` = 1 the next cycle, and requests stop until reset.
